// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect from execute, decode handshake.
interface instr_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched {instr, pc} entries; flush wins over push/pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC/credit/discard bookkeeping around a small instruction buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_VECTOR,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  instr_fetch_unit_if.master bus
);
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, count;
  logic          grant, rsp, push, pop, valid;
  fetch_entry_t  head, push_entry;

  // Credit: in-flight plus buffered never exceeds DEPTH, so a push always has room.
  assign bus.imem_req_o  = reset_n_i
                         && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_C)
                         && (outstanding < MAXO_C);
  assign bus.imem_addr_o = fetch_pc;

  assign grant = bus.imem_req_o && bus.imem_gnt_i;
  assign rsp   = bus.imem_rvalid_i && (outstanding != '0);
  assign push  = rsp && (discard == '0) && !bus.redirect_i;
  assign pop   = valid && bus.instr_ready_i && !bus.redirect_i;
  assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);

  assign push_entry = '{instr: bus.imem_rdata_i, pc: resp_pc};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_i) begin
        fetch_pc <= word_align(bus.redirect_pc_i);
        resp_pc  <= word_align(bus.redirect_pc_i);
        // Every request still in flight after this edge belongs to the old stream,
        // including ones already marked for discard.
        discard  <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (rsp) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .flush      (bus.redirect_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign valid                = (count != '0);
  assign bus.instr_valid_o    = valid;
  assign bus.instr_o          = valid ? head.instr : NOP_INSTR;
  assign bus.instr_pc_o       = valid ? head.pc : 32'd0;
  assign bus.instr_pc_plus4_o = bus.instr_pc_o + 32'd4;

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    bus.imem_rvalid_i |-> (outstanding != '0));
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch front end of the pipelined RISC-V core. Owns the fetch PC, issues word requests to instruction memory over a request/grant, in-order-response bus, buffers returned instructions with their PCs, and presents them to decode with a valid/ready handshake. Branch/jump redirects from execute flush buffered and in-flight fetches. Sits between instruction memory and the IF/ID boundary that feeds `main_decoder`.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, instruction buffer entries (power of 2, ≥2)
- `MAX_OUTSTANDING`, 2, maximum granted-but-unanswered requests (≥1, ≤DEPTH)

- `clk_i` input 1 — single clock, all state on rising edge
- `reset_n_i` input 1 — asynchronous, active-low reset
- `imem_req_o` output 1 — fetch request
- `imem_addr_o` output 32 — word-aligned fetch address (bits [1:0] always 0)
- `imem_gnt_i` input 1 — request accepted this cycle
- `imem_rvalid_i` input 1 — response data valid (responses in request order)
- `imem_rdata_i` input 32 — instruction word
- `redirect_i` input 1 — taken branch/jal/jalr from execute
- `redirect_pc_i` input 32 — new fetch PC; bits [1:0] ignored
- `instr_valid_o` output 1 — buffer head valid
- `instr_ready_i` input 1 — decode accepts head
- `instr_o` output 32 — head instruction; 32'h0000_0013 (NOP) when not valid
- `instr_pc_o` output 32 — PC of head instruction
- `instr_pc_plus4_o` output 32 — `instr_pc_o + 4`, modulo 2^32

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding` counter, `discard` counter, buffer (instr+PC per entry, read/write pointers, count).
- Request: `imem_req_o = (outstanding + count < DEPTH) && (outstanding < MAX_OUTSTANDING)`; credit rule guarantees buffer never overflows. `imem_addr_o = fetch_pc`. Address and req held stable while req && !gnt, except on redirect.
- Grant (req && gnt): `fetch_pc += 4`, `outstanding += 1`.
- Response: `outstanding -= 1`. If `discard > 0`: drop, `discard -= 1`. Else push {rdata, resp_pc}, `resp_pc += 4`.
- Pop: instr_valid_o && instr_ready_i removes head. Push and pop same cycle allowed at any occupancy.
- Redirect (highest priority): buffer flushed (count=0, pointers reset), `fetch_pc = resp_pc = {redirect_pc_i[31:2],2'b00}`, `discard = outstanding + (grant this cycle) − (response this cycle)` applied on top of current discard; response arriving in redirect cycle is dropped; pop in redirect cycle has no effect beyond flush. imem_req_o is not gated by redirect_i; a grant in the redirect cycle is counted into discard.
- PC arithmetic wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Responses with outstanding == 0 are a protocol error; ignored, counters unchanged (assert in simulation).

## Timing
- Reset values: imem_req_o 0 while reset asserted, imem_addr_o = RESET_PC, instr_valid_o 0, instr_o NOP, instr_pc_o 0, instr_pc_plus4_o 4, all counters 0, fetch_pc = resp_pc = RESET_PC.
- First request cycle after reset release: imem_req_o 1, addr RESET_PC.
- Latency: response at cycle k → instr_valid_o at k+1 (registered buffer, no bypass).
- Redirect at cycle r: cycle r+1 instr_valid_o 0, imem_addr_o = redirect PC; first new instruction valid ≥ 1 cycle after its response.
- Back-to-back: with gnt and rvalid every cycle and MAX_OUTSTANDING ≥ 2, sustained one instruction per cycle.
- Reset mid-operation: all state cleared asynchronously; post-reset responses to pre-reset requests are the memory's responsibility (memory is reset on the same net).

## Structure
- Shared package `fetch_pkg`: `NOP_INSTR` (32'h0000_0013), `RESET_VECTOR`, `fetch_entry_t` struct {instr[31:0], pc[31:0]}.
- Sub-module `fetch_buffer`: DEPTH-entry circular FIFO of `fetch_entry_t` with push, pop, flush, count output.
- Top holds PC, credit, and discard logic.

## Test plan
- Reset release, gnt=1, rvalid one cycle after each grant, ready=1 → addresses 0,4,8,…; instr_pc_o 0,4,8 consecutive cycles; pc_plus4 4,8,12.
- ready=0 with gnt/rvalid always 1, DEPTH=4 → exactly 4 entries buffered, imem_req_o 0 thereafter; ready=1 drains in order and req resumes.
- Redirect to 0x100 with 2 outstanding → both responses dropped, buffer empty next cycle, next valid instr_pc_o = 0x100.
- Redirect coincident with grant and response → discard count correct; no stale PC (old stream) ever valid after redirect.
- redirect_pc_i = 0x203 → imem_addr_o 0x200; fetch from 0xFFFF_FFFC → next address 0x0000_0000, pc_plus4 0.
- Assert reset_n_i low mid-stream with 3 buffered → instr_valid_o 0, instr_o NOP immediately; restarts at RESET_PC.
